// File: rtl/dw_btn_pkg.sv
// Shared types and default constants for the watch push-button front end.
package dw_btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } btn_state_t;

  localparam int SYNC_STAGES_DEF       = 2;
  localparam int DEBOUNCE_CYCLES_DEF   = 4;
  localparam int LONG_PRESS_CYCLES_DEF = 32;

endpackage

// File: rtl/dw_btn_debounce.sv
// One push-button: synchroniser, debounce/hold FSM, registered press and long-press events.
module dw_btn_debounce
  import dw_btn_pkg::*;
#(
  parameter int SYNC_STAGES       = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press_evt,
  output logic o_long_evt
);

  localparam int CNT_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_PRE = CNT_W'(LONG_PRESS_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LONG_PRESS_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  btn_state_t             r_state;
  logic                   r_long_done;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + ONE;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync      <= '0;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_long_done <= 1'b0;
      o_press_evt <= 1'b0;
      o_long_evt  <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], i_btn};
      o_press_evt <= 1'b0;
      o_long_evt  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_s) begin
            r_state <= DEB_PRESS;
            r_cnt   <= ONE;
          end
        end
        DEB_PRESS: begin
          if (!w_s) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt >= DEB_LAST) begin
            r_state     <= PRESSED;
            r_cnt       <= '0;
            r_long_done <= 1'b0;
            o_press_evt <= 1'b1;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        PRESSED: begin
          // Long event fires on the step into LONG_PRESS_CYCLES-1, once per press.
          if (w_s) begin
            r_cnt <= sat_inc(r_cnt);
            if (r_cnt == LONG_PRE && !r_long_done) begin
              o_long_evt  <= 1'b1;
              r_long_done <= 1'b1;
            end
          end else begin
            r_state <= DEB_RELEASE;
            r_cnt   <= ONE;
          end
        end
        DEB_RELEASE: begin
          if (w_s) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt >= DEB_LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dw_button_conditioner.sv
// Watch button front end: two debouncers feeding pending latches and a gap-enforcing arbiter.
module dw_button_conditioner
  import dw_btn_pkg::*;
#(
  parameter int SYNC_STAGES       = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mode_btn,
  input  logic set_btn,
  output logic mode,
  output logic set,
  output logic set_long,
  output logic drop_err
);

  logic w_mode_evt, w_mode_long_unused, w_set_evt, w_long_evt;
  logic r_mode_pend, r_set_pend, r_long_pend, r_gap;
  logic w_req_mode, w_req_set, w_req_long;

  dw_btn_debounce #(
    .SYNC_STAGES      (SYNC_STAGES),
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
  ) u_mode (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_btn      (mode_btn),
    .o_press_evt(w_mode_evt),
    .o_long_evt (w_mode_long_unused)
  );

  dw_btn_debounce #(
    .SYNC_STAGES      (SYNC_STAGES),
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
  ) u_set (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_btn      (set_btn),
    .o_press_evt(w_set_evt),
    .o_long_evt (w_long_evt)
  );

  // A fresh event can be emitted in the cycle it arrives, bypassing its latch.
  assign w_req_mode = r_mode_pend | w_mode_evt;
  assign w_req_set  = r_set_pend  | w_set_evt;
  assign w_req_long = r_long_pend | w_long_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_pend <= 1'b0;
      r_set_pend  <= 1'b0;
      r_long_pend <= 1'b0;
      r_gap       <= 1'b0;
      mode        <= 1'b0;
      set         <= 1'b0;
      set_long    <= 1'b0;
      drop_err    <= 1'b0;
    end else begin
      mode        <= 1'b0;
      set         <= 1'b0;
      set_long    <= 1'b0;
      r_gap       <= 1'b0;
      r_mode_pend <= w_req_mode;
      r_set_pend  <= w_req_set;
      r_long_pend <= w_req_long;
      if ((w_mode_evt & r_mode_pend) | (w_set_evt & r_set_pend) | (w_long_evt & r_long_pend))
        drop_err <= 1'b1;
      if (!r_gap) begin
        if (w_req_mode) begin
          mode        <= 1'b1;
          r_mode_pend <= 1'b0;
          r_gap       <= 1'b1;
        end else if (w_req_set) begin
          set        <= 1'b1;
          r_set_pend <= 1'b0;
          r_gap      <= 1'b1;
        end else if (w_req_long) begin
          set_long    <= 1'b1;
          r_long_pend <= 1'b0;
          r_gap       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dw_button_conditioner.sv
// Bench for dw_button_conditioner: directed scenarios plus random buttons against a behavioural model.
module tb_dw_button_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LONG = 32;
  localparam int LAT  = SYNC + DEB;

  logic clk = 1'b0;
  logic rst_n, mode_btn, set_btn;
  logic mode, set, set_long, drop_err;

  dw_button_conditioner #(
    .SYNC_STAGES      (SYNC),
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode_btn(mode_btn),
    .set_btn (set_btn),
    .mode    (mode),
    .set     (set),
    .set_long(set_long),
    .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  wire [3:0] obs = {mode, set, set_long, drop_err};

  // Model: raw delay lines, hysteresis level per button, hold-run counters, pending/gap arbiter.
  bit   q_m[$];
  bit   q_s[$];
  bit   mdl_d[2];
  int   mdl_run[2];
  int   mdl_hold[2];
  bit   mdl_ldone[2];
  bit   ev_press[2];
  bit   ev_long;
  bit   pend[3];
  bit   gap;
  bit   drop;
  logic [3:0] exp_o;

  task automatic model_reset();
    q_m.delete();
    q_s.delete();
    repeat (SYNC) begin
      q_m.push_back(1'b0);
      q_s.push_back(1'b0);
    end
    for (int b = 0; b < 2; b++) begin
      mdl_d[b] = 0; mdl_run[b] = 0; mdl_hold[b] = 0; mdl_ldone[b] = 0; ev_press[b] = 0;
    end
    ev_long = 0;
    for (int k = 0; k < 3; k++) pend[k] = 0;
    gap   = 0;
    drop  = 0;
    exp_o = 4'b0000;
  endtask

  // Level flips after DEB consecutive samples disagreeing with it; long after LONG held samples.
  task automatic deb_model(input int b, input bit s, output bit press, output bit lng);
    press = 0;
    lng   = 0;
    if (s != mdl_d[b]) mdl_run[b]++;
    else mdl_run[b] = 0;
    if (mdl_run[b] == DEB) begin
      mdl_d[b]   = s;
      mdl_run[b] = 0;
      if (s) begin
        press = 1; mdl_hold[b] = 1; mdl_ldone[b] = 0;
      end
    end else if (mdl_d[b]) begin
      if (s) begin
        mdl_hold[b]++;
        if (mdl_hold[b] == LONG && !mdl_ldone[b]) begin
          lng = 1; mdl_ldone[b] = 1;
        end
      end else begin
        mdl_hold[b] = 0;
      end
    end
  endtask

  task automatic model_step(input bit rm, input bit rs);
    bit ev[3];
    bit req[3];
    bit found;
    bit s_m, s_s, pm, ps, pl, dummy;
    ev[0] = ev_press[0];
    ev[1] = ev_press[1];
    ev[2] = ev_long;
    found = 0;
    exp_o = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      if (ev[k] && pend[k]) drop = 1;
      req[k] = pend[k] | ev[k];
    end
    for (int k = 0; k < 3; k++) begin
      if (!gap && !found && req[k]) begin
        exp_o[3-k] = 1'b1;
        req[k] = 0;
        found = 1;
      end
    end
    for (int k = 0; k < 3; k++) pend[k] = req[k];
    gap = found;
    exp_o[0] = drop;
    s_m = q_m.pop_front(); q_m.push_back(rm);
    s_s = q_s.pop_front(); q_s.push_back(rs);
    deb_model(0, s_m, pm, dummy);
    deb_model(1, s_s, ps, pl);
    ev_press[0] = pm;
    ev_press[1] = ps;
    ev_long     = pl;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(mode_btn, set_btn);
    #1;
  endtask

  task automatic idle(input int n);
    mode_btn = 0;
    set_btn  = 0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    int npulse;
    rst_n = 0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      mode_btn = 1'($urandom_range(0, 1));
      set_btn  = 1'($urandom_range(0, 1));
      tick();
      total++;
      if (obs !== 4'b0000) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%b want=0000", i, obs);
      end
    end
    mode_btn = 0;
    set_btn  = 0;
    rst_n    = 1;
    npulse   = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (obs !== exp_o) begin
        bad++;
        $display("FAIL reset_release cyc=%0d got=%b want=%b", i, obs, exp_o);
      end
      if (mode || set || set_long) npulse++;
    end
    total++;
    if (npulse != 0) begin
      bad++;
      $display("FAIL reset_quiet pulses=%0d want=0", npulse);
    end
  endtask

  task automatic test_clean_press();
    int first, nset, nlong;
    first = -1; nset = 0; nlong = 0;
    idle(20);
    for (int i = 0; i < 30; i++) begin
      set_btn = (i < 10);
      tick();
      total++;
      if (obs !== exp_o) begin
        bad++;
        $display("FAIL clean_press cyc=%0d got=%b want=%b", i, obs, exp_o);
      end
      if (set) begin
        nset++;
        if (first < 0) first = i;
      end
      if (set_long) nlong++;
    end
    total++;
    if (first != LAT) begin bad++; $display("FAIL clean_latency got=%0d want=%0d", first, LAT); end
    total++;
    if (nset != 1) begin bad++; $display("FAIL clean_count got=%0d want=1", nset); end
    total++;
    if (nlong != 0) begin bad++; $display("FAIL clean_nolong got=%0d want=0", nlong); end
  endtask

  task automatic test_bounce();
    int pat[7];
    int first, nmode;
    pat = '{1, 1, 0, 1, 1, 1, 0};
    first = -1; nmode = 0;
    idle(20);
    for (int i = 0; i < 40; i++) begin
      if (i < 7) mode_btn = pat[i][0];
      else mode_btn = (i < 25);
      tick();
      total++;
      if (obs !== exp_o) begin
        bad++;
        $display("FAIL bounce cyc=%0d got=%b want=%b", i, obs, exp_o);
      end
      if (mode) begin
        nmode++;
        if (first < 0) first = i;
      end
    end
    total++;
    if (first != 7 + LAT) begin bad++; $display("FAIL bounce_latency got=%0d want=%0d", first, 7 + LAT); end
    total++;
    if (nmode != 1) begin bad++; $display("FAIL bounce_count got=%0d want=1", nmode); end
  endtask

  task automatic test_long_press();
    int set_at[2];
    int long_at, nset, nlong;
    long_at = -1; nset = 0; nlong = 0;
    set_at[0] = -1; set_at[1] = -1;
    idle(20);
    for (int i = 0; i < 100; i++) begin
      set_btn = (i < 50) || (i >= 60 && i < 75);
      tick();
      total++;
      if (obs !== exp_o) begin
        bad++;
        $display("FAIL long_press cyc=%0d got=%b want=%b", i, obs, exp_o);
      end
      if (set) begin
        if (nset < 2) set_at[nset] = i;
        nset++;
      end
      if (set_long) begin
        nlong++;
        if (long_at < 0) long_at = i;
      end
    end
    total++;
    if (set_at[0] != LAT) begin bad++; $display("FAIL long_first_set got=%0d want=%0d", set_at[0], LAT); end
    total++;
    if (long_at != LAT + LONG - 1) begin bad++; $display("FAIL long_latency got=%0d want=%0d", long_at, LAT + LONG - 1); end
    total++;
    if (nlong != 1) begin bad++; $display("FAIL long_count got=%0d want=1", nlong); end
    total++;
    if (set_at[1] != 60 + LAT) begin bad++; $display("FAIL long_repress got=%0d want=%0d", set_at[1], 60 + LAT); end
  endtask

  task automatic test_simultaneous();
    int mode_at, set_at;
    mode_at = -1; set_at = -1;
    idle(20);
    for (int i = 0; i < 30; i++) begin
      mode_btn = (i < 12);
      set_btn  = (i < 12);
      tick();
      total++;
      if (obs !== exp_o) begin
        bad++;
        $display("FAIL simultaneous cyc=%0d got=%b want=%b", i, obs, exp_o);
      end
      if (mode && mode_at < 0) mode_at = i;
      if (set && set_at < 0) set_at = i;
    end
    total++;
    if (mode_at != LAT) begin bad++; $display("FAIL simul_mode got=%0d want=%0d", mode_at, LAT); end
    total++;
    if (set_at != LAT + 2) begin bad++; $display("FAIL simul_set got=%0d want=%0d", set_at, LAT + 2); end
  endtask

  task automatic test_reset_between();
    int nset;
    nset = 0;
    idle(20);
    mode_btn = 1;
    set_btn  = 1;
    for (int i = 0; i <= LAT; i++) tick();
    total++;
    if (mode !== 1'b1) begin bad++; $display("FAIL rb_mode got=%b want=1", mode); end
    mode_btn = 0;
    set_btn  = 0;
    rst_n    = 0;
    model_reset();
    repeat (3) tick();
    rst_n = 1;
    for (int i = 0; i < 25; i++) begin
      tick();
      total++;
      if (obs !== exp_o) begin
        bad++;
        $display("FAIL reset_between cyc=%0d got=%b want=%b", i, obs, exp_o);
      end
      if (set) nset++;
    end
    total++;
    if (nset != 0) begin bad++; $display("FAIL rb_set_dropped got=%0d want=0", nset); end
  endtask

  task automatic test_random();
    int left_m, left_s, nmode, nset, nlong;
    left_m = 0; left_s = 0; nmode = 0; nset = 0; nlong = 0;
    for (int i = 0; i < 3000; i++) begin
      if (left_m == 0) begin
        mode_btn = 1'($urandom_range(0, 1));
        left_m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 45));
      end
      if (left_s == 0) begin
        set_btn = 1'($urandom_range(0, 1));
        left_s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 45));
      end
      left_m--;
      left_s--;
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 499) == 0) begin
        rst_n = 0;
        model_reset();
      end
      tick();
      total++;
      if (obs !== exp_o) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b want=%b", i, obs, exp_o);
      end
      if (mode) nmode++;
      if (set) nset++;
      if (set_long) nlong++;
    end
    total++;
    if (nmode == 0 || nset == 0 || nlong == 0) begin
      bad++;
      $display("FAIL random_activity got mode=%0d set=%0d long=%0d want all nonzero", nmode, nset, nlong);
    end
  endtask

  initial begin
    rst_n    = 0;
    mode_btn = 0;
    set_btn  = 0;
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_simultaneous();
    test_reset_between();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
